// File: rtl/countdown_timer_if.sv
// Control/status bundle for countdown_timer: load handshake, run controls and status.
interface countdown_timer_if #(
  parameter int unsigned WIDTH = 4
) ();
  logic             load_valid;
  logic [WIDTH-1:0] load_value;
  logic             load_ready;
  logic             start;
  logic             pause;
  logic             abort;
  logic             tick_en;
  logic             auto_reload;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;

  modport master (
    output load_valid, load_value, start, pause, abort, tick_en, auto_reload,
    input  load_ready, count, busy, done
  );

  modport slave (
    input  load_valid, load_value, start, pause, abort, tick_en, auto_reload,
    output load_ready, count, busy, done
  );
endinterface

// File: rtl/countdown_timer.sv
// Loadable countdown timer: count register around a borrow-flagged decrementer,
// with IDLE/RUN/PAUSE control, registered busy, one-cycle done pulse and auto-reload.
module countdown_timer #(
  parameter int unsigned WIDTH        = 4,
  parameter bit          AUTO_DEFAULT = 1'b0
) (
  input logic              clk,
  input logic              rst_n,
  countdown_timer_if.slave bus
);

  if (WIDTH != 4) begin : g_width_check
    $error("countdown_timer: only WIDTH=4 is supported");
  end

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StRun   = 2'b01,
    StPause = 2'b10
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             auto_q, auto_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  // Decrementer: b = a + all-ones; b[WIDTH] is the borrow, set only when a == 0.
  logic [WIDTH:0] dec_sum;
  logic [WIDTH:0] dec_b;
  logic           dec_apply;

  // Decrementer datapath
  always_comb begin
    dec_sum = {1'b0, count_q} + {1'b0, {WIDTH{1'b1}}};
    dec_b   = {~dec_sum[WIDTH], dec_sum[WIDTH-1:0]};
  end

  // State and data registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      count_q  <= '0;
      reload_q <= '0;
      auto_q   <= AUTO_DEFAULT;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      auto_q   <= auto_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  // Next-state and datapath update; priority abort > load > start > pause > tick
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    reload_d  = reload_q;
    auto_d    = auto_q;
    done_d    = 1'b0;
    dec_apply = 1'b0;
    if (bus.abort) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.load_valid) begin
            count_d  = bus.load_value;
            reload_d = bus.load_value;
            auto_d   = bus.auto_reload;
          end else if (bus.start && (count_q != '0)) begin
            state_d = StRun;
          end
        end
        StRun: begin
          if (bus.pause) begin
            state_d = StPause;
          end else if (bus.tick_en) begin
            dec_apply = 1'b1;
            count_d   = dec_b[WIDTH-1:0];
            if (count_q == WIDTH'(1)) begin
              done_d = 1'b1;
              if (auto_q) begin
                count_d = reload_q;
              end else begin
                state_d = StIdle;
              end
            end
          end
        end
        StPause: begin
          if (bus.start) begin
            state_d = StRun;
          end
        end
        default: state_d = StIdle;
      endcase
    end
    busy_d = (state_d != StIdle);
  end

  // Outputs
  always_comb begin
    bus.load_ready = (state_q == StIdle);
    bus.count      = count_q;
    bus.busy       = busy_q;
    bus.done       = done_q;
  end

  // A zero count must never reach the decrementer.
  assert property (@(posedge clk) disable iff (!rst_n) dec_apply |-> !dec_b[WIDTH]);

endmodule
